// File: rtl/digit_serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of DIGIT-wide slices in a WIDTH-bit operand; guarded so a bad
  // DIGIT cannot divide by zero before the elaboration check fires.
  function automatic int calc_num_digits(input int width, input int digit);
    return (digit > 0) ? (width / digit) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_adder_add_digit.sv
// One DIGIT-bit ripple slice; the only arithmetic in the adder, purely combinational.
module add_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             x_msb,
  output logic             y_msb
);

  logic [DIGIT:0] total;

  always_comb begin
    total = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
  end

  assign s     = total[DIGIT-1:0];
  assign co    = total[DIGIT];
  assign x_msb = x[DIGIT-1];
  assign y_msb = y[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: one DIGIT-bit slice per cycle, valid/ready on both sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand set
// BUSY  | adding slice idx_q, carry held in carry_q
// DONE  | result held on sum/cout/ovf until out_ready
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  import digit_serial_adder_pkg::*;

  localparam int N  = calc_num_digits(WIDTH, DIGIT);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if ((DIGIT < 1) || ((WIDTH % ((DIGIT < 1) ? 1 : DIGIT)) != 0)) begin : g_bad_params
    $fatal(1, "digit_serial_adder: WIDTH must be a multiple of DIGIT, DIGIT >= 1");
  end

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, in_ready_q, out_valid_q;
  logic             accept;
  logic [31:0]      lsb;
  logic [DIGIT-1:0] s_dig;
  logic             co_dig, x_msb, y_msb;

  assign accept = in_valid && in_ready_q && (state_q == IDLE);
  assign lsb    = 32'(idx_q) * DIGIT;

  add_digit #(.DIGIT(DIGIT)) u_add_digit (
    .x     (a_q[lsb +: DIGIT]),
    .y     (b_q[lsb +: DIGIT]),
    .ci    (carry_q),
    .s     (s_dig),
    .co    (co_dig),
    .x_msb (x_msb),
    .y_msb (y_msb)
  );

  always_comb begin
    res_d = res_q;
    res_d[lsb +: DIGIT] = s_dig;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (idx_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      if (accept) begin
        // Subtract is folded into the operands here: a + ~b + ~cin.
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= cin ^ sub;
        idx_q   <= '0;
      end else if (state_q == BUSY) begin
        res_q   <= res_d;
        carry_q <= co_dig;
        idx_q   <= idx_q + 1'b1;
        if (idx_q == LAST) begin
          idx_q  <= '0;
          sum_q  <= res_d;
          cout_q <= co_dig;
          ovf_q  <= (x_msb == y_msb) && (s_dig[DIGIT-1] != x_msb);
        end
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
